// File: rtl/axi_lite_arbiter_if.sv
// AXI4-lite bundle shared by the IFU, LSU and slave sides of the arbiter.
// master drives address/data/ready-for-response; slave drives the rest.
interface axi_lite_arbiter_if;
  logic [31:0] araddr;
  logic [2:0]  arsize;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    output araddr, arsize, arvalid,
    input  arready,
    input  rdata, rresp, rvalid,
    output rready,
    output awaddr, awvalid,
    input  awready,
    output wdata, wstrb, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready
  );

  modport slave (
    input  araddr, arsize, arvalid,
    output arready,
    output rdata, rresp, rvalid,
    input  rready,
    input  awaddr, awvalid,
    output awready,
    input  wdata, wstrb, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready
  );
endinterface

// File: rtl/axi_lite_arbiter.sv
// Two-master (IFU read-only, LSU read/write) to one AXI4-lite slave arbiter.
// One transaction in flight; fixed priority LSU write > LSU read > IFU read.
module axi_lite_arbiter #(
  parameter logic [2:0] IFU_ARSIZE = 3'b010
) (
  input logic               clk,
  input logic               rst,
  axi_lite_arbiter_if.slave  ifu,
  axi_lite_arbiter_if.slave  lsu,
  axi_lite_arbiter_if.master s
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] IFU_RD = 2'd1;
  localparam logic [1:0] LSU_RD = 2'd2;
  localparam logic [1:0] LSU_WR = 2'd3;

  logic [1:0] state_q, state_d;
  logic       ar_done_q, ar_done_d;
  logic       aw_done_q, aw_done_d;
  logic       w_done_q, w_done_d;
  logic       arb_en_q, arb_en_d;

  logic wr_req;
  logic lrd_req;
  logic ird_req;
  logic ar_hs;
  logic r_hs;
  logic aw_hs;
  logic w_hs;
  logic b_hs;

  logic unused_ifu;
  assign unused_ifu = ^{ifu.arsize, ifu.awaddr,
                        ifu.awvalid, ifu.wdata,
                        ifu.wstrb, ifu.wvalid,
                        ifu.bready};

  // Requests reduced to one-hot by priority
  always_comb begin
    wr_req  = lsu.awvalid | lsu.wvalid;
    lrd_req = lsu.arvalid & ~wr_req;
    ird_req = ifu.arvalid & ~lsu.arvalid
            & ~wr_req;
  end

  always_comb begin : route
    s.araddr    = '0;
    s.arsize    = '0;
    s.arvalid   = 1'b0;
    s.rready    = 1'b0;
    s.awaddr    = '0;
    s.awvalid   = 1'b0;
    s.wdata     = '0;
    s.wstrb     = '0;
    s.wvalid    = 1'b0;
    s.bready    = 1'b0;
    ifu.arready = 1'b0;
    ifu.rdata   = '0;
    ifu.rresp   = '0;
    ifu.rvalid  = 1'b0;
    ifu.awready = 1'b0;
    ifu.wready  = 1'b0;
    ifu.bresp   = '0;
    ifu.bvalid  = 1'b0;
    lsu.arready = 1'b0;
    lsu.rdata   = '0;
    lsu.rresp   = '0;
    lsu.rvalid  = 1'b0;
    lsu.awready = 1'b0;
    lsu.wready  = 1'b0;
    lsu.bresp   = '0;
    lsu.bvalid  = 1'b0;
    unique case (state_q)
      IFU_RD: begin
        s.araddr    = ifu.araddr;
        s.arsize    = IFU_ARSIZE;
        s.arvalid   = ifu.arvalid & ~ar_done_q;
        ifu.arready = s.arready & ~ar_done_q;
        ifu.rdata   = s.rdata;
        ifu.rresp   = s.rresp;
        ifu.rvalid  = s.rvalid;
        s.rready    = ifu.rready;
      end
      LSU_RD: begin
        s.araddr    = lsu.araddr;
        s.arsize    = lsu.arsize;
        s.arvalid   = lsu.arvalid & ~ar_done_q;
        lsu.arready = s.arready & ~ar_done_q;
        lsu.rdata   = s.rdata;
        lsu.rresp   = s.rresp;
        lsu.rvalid  = s.rvalid;
        s.rready    = lsu.rready;
      end
      LSU_WR: begin
        s.awaddr    = lsu.awaddr;
        s.awvalid   = lsu.awvalid & ~aw_done_q;
        lsu.awready = s.awready & ~aw_done_q;
        s.wdata     = lsu.wdata;
        s.wstrb     = lsu.wstrb;
        s.wvalid    = lsu.wvalid & ~w_done_q;
        lsu.wready  = s.wready & ~w_done_q;
        lsu.bresp   = s.bresp;
        lsu.bvalid  = s.bvalid;
        s.bready    = lsu.bready;
      end
      default: ;
    endcase
  end

  always_comb begin
    ar_hs = s.arvalid & s.arready;
    r_hs  = s.rvalid & s.rready;
    aw_hs = s.awvalid & s.awready;
    w_hs  = s.wvalid & s.wready;
    b_hs  = s.bvalid & s.bready;
  end

  always_comb begin : next
    state_d   = state_q;
    ar_done_d = ar_done_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    arb_en_d  = 1'b1;
    unique case (state_q)
      IDLE: begin
        ar_done_d = 1'b0;
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        // Hold off one edge after reset release
        if (arb_en_q) begin
          unique case (1'b1)
            wr_req:  state_d = LSU_WR;
            lrd_req: state_d = LSU_RD;
            ird_req: state_d = IFU_RD;
            default: state_d = IDLE;
          endcase
        end
      end
      IFU_RD, LSU_RD: begin
        if (ar_hs) ar_done_d = 1'b1;
        if (r_hs) begin
          state_d   = IDLE;
          ar_done_d = 1'b0;
        end
      end
      LSU_WR: begin
        if (aw_hs) aw_done_d = 1'b1;
        if (w_hs)  w_done_d  = 1'b1;
        if (b_hs) begin
          state_d   = IDLE;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      ar_done_q <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      arb_en_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      ar_done_q <= ar_done_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      arb_en_q  <= arb_en_d;
    end
  end

endmodule

// File: tb/tb_axi_lite_arbiter.sv
// Scripted scenarios against axi_lite_arbiter with a response scoreboard.
// Inputs change 1 time unit after posedge; outputs are read at negedge.
module tb_axi_lite_arbiter;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  typedef struct {
    logic [1:0]  kind;
    logic [31:0] data;
    logic [1:0]  resp;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  axi_lite_arbiter_if ifu_bus();
  axi_lite_arbiter_if lsu_bus();
  axi_lite_arbiter_if s_bus();

  axi_lite_arbiter #(
    .IFU_ARSIZE(3'b010)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ifu(ifu_bus),
    .lsu(lsu_bus),
    .s(s_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  function automatic logic any_hs();
    return s_bus.arvalid | s_bus.rready
         | s_bus.awvalid | s_bus.wvalid
         | s_bus.bready
         | ifu_bus.arready | ifu_bus.rvalid
         | ifu_bus.awready | ifu_bus.wready
         | ifu_bus.bvalid
         | lsu_bus.arready | lsu_bus.rvalid
         | lsu_bus.awready | lsu_bus.wready
         | lsu_bus.bvalid;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Response monitor: kind 0 = IFU r, 1 = LSU r, 2 = LSU b
  always @(negedge clk) begin
    if (rst) begin
      if (ifu_bus.rvalid && ifu_bus.rready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_ifu got=%h exp=none",
                   ifu_bus.rdata);
        end else begin
          e = sb.pop_front();
          if ({2'd0, ifu_bus.rdata, ifu_bus.rresp}
              !== {e.kind, e.data, e.resp}) begin
            errors++;
            $display("FAIL sb_ifu got=%h/%h exp=%0d:%h/%h",
                     ifu_bus.rdata, ifu_bus.rresp,
                     e.kind, e.data, e.resp);
          end
        end
      end
      if (lsu_bus.rvalid && lsu_bus.rready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_lsu_r got=%h exp=none",
                   lsu_bus.rdata);
        end else begin
          e = sb.pop_front();
          if ({2'd1, lsu_bus.rdata, lsu_bus.rresp}
              !== {e.kind, e.data, e.resp}) begin
            errors++;
            $display("FAIL sb_lsu_r got=%h/%h exp=%0d:%h/%h",
                     lsu_bus.rdata, lsu_bus.rresp,
                     e.kind, e.data, e.resp);
          end
        end
      end
      if (lsu_bus.bvalid && lsu_bus.bready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_lsu_b got=%h exp=none",
                   lsu_bus.bresp);
        end else begin
          e = sb.pop_front();
          if ({2'd2, lsu_bus.bresp}
              !== {e.kind, e.resp}) begin
            errors++;
            $display("FAIL sb_lsu_b got=%h exp=%0d:%h",
                     lsu_bus.bresp, e.kind, e.resp);
          end
        end
      end
    end
  end

  task automatic init_inputs();
    ifu_bus.araddr  = '0;
    ifu_bus.arsize  = '0;
    ifu_bus.arvalid = 1'b0;
    ifu_bus.rready  = 1'b0;
    ifu_bus.awaddr  = '0;
    ifu_bus.awvalid = 1'b0;
    ifu_bus.wdata   = '0;
    ifu_bus.wstrb   = '0;
    ifu_bus.wvalid  = 1'b0;
    ifu_bus.bready  = 1'b0;
    lsu_bus.araddr  = '0;
    lsu_bus.arsize  = '0;
    lsu_bus.arvalid = 1'b0;
    lsu_bus.rready  = 1'b0;
    lsu_bus.awaddr  = '0;
    lsu_bus.awvalid = 1'b0;
    lsu_bus.wdata   = '0;
    lsu_bus.wstrb   = '0;
    lsu_bus.wvalid  = 1'b0;
    lsu_bus.bready  = 1'b0;
    s_bus.arready   = 1'b0;
    s_bus.rdata     = '0;
    s_bus.rresp     = '0;
    s_bus.rvalid    = 1'b0;
    s_bus.awready   = 1'b0;
    s_bus.wready    = 1'b0;
    s_bus.bresp     = '0;
    s_bus.bvalid    = 1'b0;
  endtask

  task automatic test_reset();
    cyc();
    ifu_bus.araddr  = 32'h0000_0100;
    ifu_bus.arvalid = 1'b1;
    ifu_bus.rready  = 1'b1;
    @(negedge clk);
    checks++;
    if (any_hs() !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle got=%b exp=0", any_hs());
    end
    cyc();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (s_bus.arvalid !== 1'b0) begin
      errors++;
      $display("FAIL rst_rel0 got=%b exp=0", s_bus.arvalid);
    end
    cyc();
    @(negedge clk);
    checks++;
    if (s_bus.arvalid !== 1'b0) begin
      errors++;
      $display("FAIL rst_rel1 got=%b exp=0", s_bus.arvalid);
    end
    cyc();
    @(negedge clk);
    checks++;
    if ({s_bus.arvalid, s_bus.araddr}
        !== {1'b1, 32'h0000_0100}) begin
      errors++;
      $display("FAIL rst_rel2 got=%b/%h exp=1/00000100",
               s_bus.arvalid, s_bus.araddr);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (any_hs() !== 1'b0) begin
      errors++;
      $display("FAIL rst_async got=%b exp=0", any_hs());
    end
    ifu_bus.arvalid = 1'b0;
    cyc();
    rst = 1'b1;
    cyc();
    cyc();
  endtask

  task automatic test_ifu_read();
    cyc();
    ifu_bus.araddr  = 32'h8000_0000;
    ifu_bus.arvalid = 1'b1;
    ifu_bus.rready  = 1'b1;
    sb.push_back('{2'd0, 32'h0000_0413, 2'b00});
    @(negedge clk);
    checks++;
    if (s_bus.arvalid !== 1'b0) begin
      errors++;
      $display("FAIL ifu_latency got=%b exp=0", s_bus.arvalid);
    end
    cyc();
    @(negedge clk);
    checks++;
    if ({s_bus.arvalid, s_bus.araddr, s_bus.arsize}
        !== {1'b1, 32'h8000_0000, 3'b010}) begin
      errors++;
      $display("FAIL ifu_ar got=%b/%h/%b exp=1/80000000/010",
               s_bus.arvalid, s_bus.araddr, s_bus.arsize);
    end
    checks++;
    if ({lsu_bus.arready, lsu_bus.rvalid,
         lsu_bus.awready, lsu_bus.wready,
         lsu_bus.bvalid} !== 5'b0) begin
      errors++;
      $display("FAIL ifu_lsu_quiet got=%b%b%b%b%b exp=00000",
               lsu_bus.arready, lsu_bus.rvalid,
               lsu_bus.awready, lsu_bus.wready,
               lsu_bus.bvalid);
    end
    cyc();
    cyc();
    s_bus.arready = 1'b1;
    @(negedge clk);
    checks++;
    if (ifu_bus.arready !== 1'b1) begin
      errors++;
      $display("FAIL ifu_arready got=%b exp=1", ifu_bus.arready);
    end
    cyc();
    @(negedge clk);
    checks++;
    if ({s_bus.arvalid, ifu_bus.arready} !== 2'b00) begin
      errors++;
      $display("FAIL ifu_ar_done got=%b%b exp=00",
               s_bus.arvalid, ifu_bus.arready);
    end
    cyc();
    s_bus.arready   = 1'b0;
    ifu_bus.arvalid = 1'b0;
    s_bus.rvalid    = 1'b1;
    s_bus.rdata     = 32'h0000_0413;
    s_bus.rresp     = 2'b00;
    @(negedge clk);
    checks++;
    if ({ifu_bus.rvalid, ifu_bus.rdata, s_bus.rready}
        !== {1'b1, 32'h0000_0413, 1'b1}) begin
      errors++;
      $display("FAIL ifu_rdata got=%b/%h/%b exp=1/00000413/1",
               ifu_bus.rvalid, ifu_bus.rdata, s_bus.rready);
    end
    cyc();
    s_bus.rvalid = 1'b0;
    s_bus.rdata  = '0;
    @(negedge clk);
    checks++;
    if (any_hs() !== 1'b0) begin
      errors++;
      $display("FAIL ifu_idle got=%b exp=0", any_hs());
    end
  endtask

  task automatic test_priority();
    cyc();
    ifu_bus.araddr  = 32'h8000_0010;
    ifu_bus.arvalid = 1'b1;
    ifu_bus.rready  = 1'b1;
    lsu_bus.araddr  = 32'h1000_0004;
    lsu_bus.arsize  = 3'b001;
    lsu_bus.arvalid = 1'b1;
    lsu_bus.rready  = 1'b1;
    sb.push_back('{2'd1, 32'h5555_AAAA, 2'b00});
    sb.push_back('{2'd0, 32'h1111_2222, 2'b00});
    @(negedge clk);
    checks++;
    if (s_bus.arvalid !== 1'b0) begin
      errors++;
      $display("FAIL prio_latency got=%b exp=0", s_bus.arvalid);
    end
    cyc();
    s_bus.arready = 1'b1;
    @(negedge clk);
    checks++;
    if ({s_bus.arvalid, s_bus.araddr, s_bus.arsize}
        !== {1'b1, 32'h1000_0004, 3'b001}) begin
      errors++;
      $display("FAIL prio_lsu_first got=%b/%h/%b exp=1/10000004/001",
               s_bus.arvalid, s_bus.araddr, s_bus.arsize);
    end
    checks++;
    if ({lsu_bus.arready, ifu_bus.arready} !== 2'b10) begin
      errors++;
      $display("FAIL prio_ready got=%b%b exp=10",
               lsu_bus.arready, ifu_bus.arready);
    end
    cyc();
    s_bus.arready   = 1'b0;
    lsu_bus.arvalid = 1'b0;
    s_bus.rvalid    = 1'b1;
    s_bus.rdata     = 32'h5555_AAAA;
    s_bus.rresp     = 2'b00;
    @(negedge clk);
    checks++;
    if (ifu_bus.rvalid !== 1'b0) begin
      errors++;
      $display("FAIL prio_ifu_blocked got=%b exp=0",
               ifu_bus.rvalid);
    end
    cyc();
    s_bus.rvalid = 1'b0;
    @(negedge clk);
    checks++;
    if (s_bus.arvalid !== 1'b0) begin
      errors++;
      $display("FAIL prio_idle_gap got=%b exp=0", s_bus.arvalid);
    end
    cyc();
    s_bus.arready = 1'b1;
    @(negedge clk);
    checks++;
    if ({s_bus.arvalid, s_bus.araddr, s_bus.arsize}
        !== {1'b1, 32'h8000_0010, 3'b010}) begin
      errors++;
      $display("FAIL prio_ifu_second got=%b/%h/%b exp=1/80000010/010",
               s_bus.arvalid, s_bus.araddr, s_bus.arsize);
    end
    cyc();
    s_bus.arready   = 1'b0;
    ifu_bus.arvalid = 1'b0;
    s_bus.rvalid    = 1'b1;
    s_bus.rdata     = 32'h1111_2222;
    cyc();
    s_bus.rvalid = 1'b0;
    @(negedge clk);
    checks++;
    if (any_hs() !== 1'b0) begin
      errors++;
      $display("FAIL prio_idle got=%b exp=0", any_hs());
    end
  endtask

  task automatic test_write_split();
    cyc();
    lsu_bus.awaddr  = 32'h2000_0008;
    lsu_bus.awvalid = 1'b1;
    lsu_bus.wdata   = 32'hDEAD_BEEF;
    lsu_bus.wstrb   = 4'b1111;
    lsu_bus.wvalid  = 1'b1;
    lsu_bus.bready  = 1'b1;
    ifu_bus.araddr  = 32'h8000_0020;
    ifu_bus.arvalid = 1'b1;
    sb.push_back('{2'd2, 32'h0, 2'b00});
    @(negedge clk);
    checks++;
    if ({s_bus.awvalid, s_bus.wvalid} !== 2'b00) begin
      errors++;
      $display("FAIL wr_latency got=%b%b exp=00",
               s_bus.awvalid, s_bus.wvalid);
    end
    cyc();
    s_bus.awready = 1'b1;
    @(negedge clk);
    checks++;
    if ({s_bus.awvalid, s_bus.awaddr, s_bus.wvalid,
         s_bus.wdata, s_bus.wstrb}
        !== {1'b1, 32'h2000_0008, 1'b1,
             32'hDEAD_BEEF, 4'b1111}) begin
      errors++;
      $display("FAIL wr_fwd got=%b/%h/%b/%h/%b exp=1/20000008/1/deadbeef/1111",
               s_bus.awvalid, s_bus.awaddr, s_bus.wvalid,
               s_bus.wdata, s_bus.wstrb);
    end
    checks++;
    if ({lsu_bus.awready, lsu_bus.wready,
         ifu_bus.arready, s_bus.arvalid} !== 4'b1000) begin
      errors++;
      $display("FAIL wr_aw_ready got=%b%b%b%b exp=1000",
               lsu_bus.awready, lsu_bus.wready,
               ifu_bus.arready, s_bus.arvalid);
    end
    cyc();
    s_bus.awready = 1'b0;
    @(negedge clk);
    checks++;
    if ({s_bus.awvalid, s_bus.wvalid} !== 2'b01) begin
      errors++;
      $display("FAIL wr_aw_done got=%b%b exp=01",
               s_bus.awvalid, s_bus.wvalid);
    end
    cyc();
    lsu_bus.awvalid = 1'b0;
    cyc();
    s_bus.wready = 1'b1;
    @(negedge clk);
    checks++;
    if (lsu_bus.wready !== 1'b1) begin
      errors++;
      $display("FAIL wr_w_ready got=%b exp=1", lsu_bus.wready);
    end
    cyc();
    s_bus.bvalid = 1'b1;
    s_bus.bresp  = 2'b00;
    @(negedge clk);
    checks++;
    if ({s_bus.wvalid, lsu_bus.wready,
         lsu_bus.bvalid, ifu_bus.arready} !== 4'b0010) begin
      errors++;
      $display("FAIL wr_w_done got=%b%b%b%b exp=0010",
               s_bus.wvalid, lsu_bus.wready,
               lsu_bus.bvalid, ifu_bus.arready);
    end
    cyc();
    s_bus.bvalid    = 1'b0;
    s_bus.wready    = 1'b0;
    lsu_bus.wvalid  = 1'b0;
    ifu_bus.arvalid = 1'b0;
    @(negedge clk);
    checks++;
    if (any_hs() !== 1'b0) begin
      errors++;
      $display("FAIL wr_idle got=%b exp=0", any_hs());
    end
  endtask

  task automatic test_write_same();
    cyc();
    lsu_bus.awaddr  = 32'h2000_000C;
    lsu_bus.awvalid = 1'b1;
    lsu_bus.wdata   = 32'h0123_4567;
    lsu_bus.wstrb   = 4'b0011;
    lsu_bus.wvalid  = 1'b1;
    lsu_bus.bready  = 1'b1;
    sb.push_back('{2'd2, 32'h0, 2'b01});
    cyc();
    s_bus.awready = 1'b1;
    s_bus.wready  = 1'b1;
    @(negedge clk);
    checks++;
    if ({lsu_bus.awready, lsu_bus.wready} !== 2'b11) begin
      errors++;
      $display("FAIL same_ready got=%b%b exp=11",
               lsu_bus.awready, lsu_bus.wready);
    end
    cyc();
    s_bus.awready = 1'b0;
    s_bus.wready  = 1'b0;
    s_bus.bvalid  = 1'b1;
    s_bus.bresp   = 2'b01;
    @(negedge clk);
    checks++;
    if ({s_bus.awvalid, s_bus.wvalid} !== 2'b00) begin
      errors++;
      $display("FAIL same_flags got=%b%b exp=00",
               s_bus.awvalid, s_bus.wvalid);
    end
    checks++;
    if ({lsu_bus.bvalid, lsu_bus.bresp} !== 3'b101) begin
      errors++;
      $display("FAIL same_b got=%b/%b exp=1/01",
               lsu_bus.bvalid, lsu_bus.bresp);
    end
    cyc();
    s_bus.bvalid    = 1'b0;
    lsu_bus.awvalid = 1'b0;
    lsu_bus.wvalid  = 1'b0;
    @(negedge clk);
    checks++;
    if (any_hs() !== 1'b0) begin
      errors++;
      $display("FAIL same_idle got=%b exp=0", any_hs());
    end
  endtask

  task automatic test_early_b();
    cyc();
    lsu_bus.awvalid = 1'b1;
    lsu_bus.wvalid  = 1'b1;
    lsu_bus.bready  = 1'b1;
    sb.push_back('{2'd2, 32'h0, 2'b10});
    cyc();
    s_bus.bvalid = 1'b1;
    s_bus.bresp  = 2'b10;
    @(negedge clk);
    checks++;
    if ({lsu_bus.bvalid, lsu_bus.bresp, s_bus.awvalid}
        !== 4'b1101) begin
      errors++;
      $display("FAIL early_b got=%b/%b/%b exp=1/10/1",
               lsu_bus.bvalid, lsu_bus.bresp, s_bus.awvalid);
    end
    cyc();
    s_bus.bvalid    = 1'b0;
    lsu_bus.awvalid = 1'b0;
    lsu_bus.wvalid  = 1'b0;
    @(negedge clk);
    checks++;
    if (any_hs() !== 1'b0) begin
      errors++;
      $display("FAIL early_idle got=%b exp=0", any_hs());
    end
  endtask

  task automatic test_reset_mid();
    cyc();
    lsu_bus.araddr  = 32'h1000_0040;
    lsu_bus.arsize  = 3'b010;
    lsu_bus.arvalid = 1'b1;
    lsu_bus.rready  = 1'b1;
    cyc();
    @(negedge clk);
    checks++;
    if ({s_bus.arvalid, s_bus.araddr}
        !== {1'b1, 32'h1000_0040}) begin
      errors++;
      $display("FAIL mid_lsu_rd got=%b/%h exp=1/10000040",
               s_bus.arvalid, s_bus.araddr);
    end
    cyc();
    s_bus.arready = 1'b1;
    cyc();
    s_bus.arready   = 1'b0;
    lsu_bus.arvalid = 1'b0;
    cyc();
    rst          = 1'b0;
    s_bus.rvalid = 1'b1;
    s_bus.rdata  = 32'hFFFF_0000;
    #1;
    checks++;
    if (any_hs() !== 1'b0) begin
      errors++;
      $display("FAIL mid_rst got=%b exp=0", any_hs());
    end
    @(negedge clk);
    checks++;
    if (lsu_bus.rvalid !== 1'b0) begin
      errors++;
      $display("FAIL mid_rst_hold got=%b exp=0", lsu_bus.rvalid);
    end
    cyc();
    s_bus.rvalid = 1'b0;
    s_bus.rdata  = '0;
    rst          = 1'b1;
    cyc();
    ifu_bus.araddr  = 32'h8000_0100;
    ifu_bus.arvalid = 1'b1;
    ifu_bus.rready  = 1'b1;
    sb.push_back('{2'd0, 32'h0000_0013, 2'b00});
    cyc();
    s_bus.arready = 1'b1;
    @(negedge clk);
    checks++;
    if ({s_bus.arvalid, s_bus.araddr}
        !== {1'b1, 32'h8000_0100}) begin
      errors++;
      $display("FAIL mid_ifu_ar got=%b/%h exp=1/80000100",
               s_bus.arvalid, s_bus.araddr);
    end
    cyc();
    s_bus.arready   = 1'b0;
    ifu_bus.arvalid = 1'b0;
    s_bus.rvalid    = 1'b1;
    s_bus.rdata     = 32'h0000_0013;
    @(negedge clk);
    checks++;
    if (ifu_bus.rvalid !== 1'b1) begin
      errors++;
      $display("FAIL mid_ifu_r got=%b exp=1", ifu_bus.rvalid);
    end
    cyc();
    s_bus.rvalid = 1'b0;
    @(negedge clk);
    checks++;
    if (any_hs() !== 1'b0) begin
      errors++;
      $display("FAIL mid_idle got=%b exp=0", any_hs());
    end
  endtask

  task automatic test_rresp_err();
    cyc();
    lsu_bus.araddr  = 32'h1000_0080;
    lsu_bus.arsize  = 3'b000;
    lsu_bus.arvalid = 1'b1;
    lsu_bus.rready  = 1'b1;
    sb.push_back('{2'd1, 32'hCAFE_0000, 2'b10});
    cyc();
    s_bus.arready = 1'b1;
    cyc();
    s_bus.arready   = 1'b0;
    lsu_bus.arvalid = 1'b0;
    s_bus.rvalid    = 1'b1;
    s_bus.rdata     = 32'hCAFE_0000;
    s_bus.rresp     = 2'b10;
    @(negedge clk);
    checks++;
    if ({lsu_bus.rvalid, lsu_bus.rresp} !== 3'b110) begin
      errors++;
      $display("FAIL err_rresp got=%b/%b exp=1/10",
               lsu_bus.rvalid, lsu_bus.rresp);
    end
    checks++;
    if (ifu_bus.rvalid !== 1'b0) begin
      errors++;
      $display("FAIL err_ifu_quiet got=%b exp=0", ifu_bus.rvalid);
    end
    cyc();
    s_bus.rvalid = 1'b0;
    s_bus.rresp  = 2'b00;
    @(negedge clk);
    checks++;
    if (any_hs() !== 1'b0) begin
      errors++;
      $display("FAIL err_idle got=%b exp=0", any_hs());
    end
  endtask

  task automatic test_valid_drop();
    cyc();
    lsu_bus.araddr  = 32'h1000_00C0;
    lsu_bus.arvalid = 1'b1;
    lsu_bus.rready  = 1'b1;
    sb.push_back('{2'd1, 32'h0BAD_F00D, 2'b00});
    cyc();
    lsu_bus.arvalid = 1'b0;
    ifu_bus.araddr  = 32'h8000_0200;
    ifu_bus.arvalid = 1'b1;
    ifu_bus.rready  = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if ({s_bus.rready, s_bus.arvalid, ifu_bus.arready}
          !== 3'b100) begin
        errors++;
        $display("FAIL drop_grant_held%0d got=%b%b%b exp=100",
                 i, s_bus.rready, s_bus.arvalid,
                 ifu_bus.arready);
      end
      cyc();
    end
    s_bus.rvalid = 1'b1;
    s_bus.rdata  = 32'h0BAD_F00D;
    @(negedge clk);
    checks++;
    if (lsu_bus.rvalid !== 1'b1) begin
      errors++;
      $display("FAIL drop_rvalid got=%b exp=1", lsu_bus.rvalid);
    end
    cyc();
    s_bus.rvalid    = 1'b0;
    ifu_bus.arvalid = 1'b0;
    @(negedge clk);
    checks++;
    if (any_hs() !== 1'b0) begin
      errors++;
      $display("FAIL drop_idle got=%b exp=0", any_hs());
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b0;
    init_inputs();
    test_reset();
    test_ifu_read();
    test_priority();
    test_write_split();
    test_write_same();
    test_early_b();
    test_reset_mid();
    test_rresp_err();
    test_valid_drop();
    cyc();
    @(negedge clk);
    checks++;
    if (sb.size() !== 0) begin
      errors++;
      $display("FAIL sb_empty got=%0d exp=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_lite_arbiter.md
AXI_LITE_ARBITER -- requirements
Module: axi_lite_arbiter

Interface
- REQ-001 SHALL have parameter IFU_ARSIZE, default 3'b010: arsize driven to the slave for IFU reads.
- REQ-002 SHALL have clk, input, 1: the only clock; all state updates on the rising edge.
- REQ-003 SHALL have rst, input, 1: asynchronous, active-low reset.
- REQ-004 SHALL have IFU read-address ports: ifu_araddr in 32, ifu_arvalid in 1, ifu_arready out 1.
- REQ-005 SHALL have IFU read-data ports: ifu_rdata out 32, ifu_rresp out 2, ifu_rvalid out 1, ifu_rready in 1.
- REQ-006 SHALL have LSU read-address ports: lsu_araddr in 32, lsu_arvalid in 1, lsu_arready out 1, lsu_arsize in 3.
- REQ-007 SHALL have LSU read-data ports: lsu_rdata out 32, lsu_rresp out 2, lsu_rvalid out 1, lsu_rready in 1.
- REQ-008 SHALL have LSU write-address ports: lsu_awaddr in 32, lsu_awvalid in 1, lsu_awready out 1.
- REQ-009 SHALL have LSU write-data ports: lsu_wdata in 32, lsu_wstrb in 4, lsu_wvalid in 1, lsu_wready out 1.
- REQ-010 SHALL have LSU write-response ports: lsu_bresp out 2, lsu_bvalid out 1, lsu_bready in 1.
- REQ-011 SHALL have slave-side AXI4-lite ports s_* (araddr, arsize, arvalid, arready, rdata, rresp, rvalid, rready, awaddr, awvalid, awready, wdata, wstrb, wvalid, wready, bresp, bvalid, bready), with directions mirrored from the master side.

Function
- REQ-012 SHALL implement a state machine with states IDLE, IFU_RD, LSU_RD and LSU_WR; only one transaction is outstanding at a time.
- REQ-013 IDLE SHALL select by fixed priority: lsu_awvalid|lsu_wvalid -> LSU_WR; else lsu_arvalid -> LSU_RD; else ifu_arvalid -> IFU_RD; else stay in IDLE.
- REQ-014 In IDLE, every s_*valid, s_*ready and master-side ready/valid output SHALL be 0; the grant takes effect the cycle after the request is seen (1-cycle arbitration latency, no combinational path from request to slave valid).
- REQ-015 In IFU_RD, s_araddr/s_arvalid SHALL come from the IFU and s_arsize SHALL equal IFU_ARSIZE; s_arready, s_r* and ifu_rready SHALL be routed to and from the IFU; all LSU handshake outputs SHALL be 0.
- REQ-016 In LSU_RD, the read channels SHALL be routed to and from the LSU, with s_arsize=lsu_arsize; all IFU handshake outputs SHALL be 0.
- REQ-017 LSU_RD and IFU_RD SHALL return to IDLE on the cycle after s_rvalid&&s_rready.
- REQ-018 After s_arvalid&&s_arready in a read state, an ar_done flag SHALL be set and SHALL force s_arvalid=0 and the master's arready=0 until the state is left.
- REQ-019 LSU_WR SHALL route the aw, w and b channels independently; aw_done/w_done SHALL set on their respective handshakes and then mask s_awvalid/s_wvalid and lsu_awready/lsu_wready to 0.
- REQ-020 Same-cycle aw and w handshakes SHALL set both flags in that cycle.
- REQ-021 LSU_WR SHALL return to IDLE on the cycle after s_bvalid&&s_bready.
- REQ-022 s_bvalid asserting before both aw_done and w_done are set SHALL still be forwarded.
- REQ-023 ar_done, aw_done and w_done SHALL clear on every transition into IDLE.
- REQ-024 Data and address buses of non-granted masters SHALL be driven 0; the arbiter registers no data (pure mux), so rdata/bresp timing equals the slave's.
- REQ-025 A master dropping its valid before the handshake SHALL NOT change the grant; the grant is released only per REQ-017 and REQ-021.

Reset
- REQ-026 While rst=0 (asynchronous), state SHALL be IDLE, all flags 0 and all valid/ready outputs 0.
- REQ-027 A reset asserted mid-transaction SHALL abandon the transaction with no response to either master.
- REQ-028 The first grant after rst rises SHALL occur no earlier than the second rising edge.

Verification
- REQ-029 IFU-only read: ifu_araddr=0x80000000, slave arready after 2 cycles, rvalid with rdata=0x00000413 -> ifu_rdata=0x00000413, s_arsize=3'b010, back to IDLE.
- REQ-030 Simultaneous ifu_arvalid and lsu_arvalid -> LSU granted first (s_araddr=lsu_araddr); IFU granted only after LSU's r handshake plus one IDLE cycle.
- REQ-031 LSU write with awready 3 cycles before wready, wdata=0xDEADBEEF, wstrb=4'b1111 -> s_awvalid drops after the aw handshake; bresp=2'b00 reaches lsu_bresp; IFU sees no ready.
- REQ-032 LSU write with aw and w accepted in the same cycle, slave bvalid next cycle -> both flags set, lsu_bvalid=1, IDLE the cycle after bready.
- REQ-033 rst pulled low during LSU_RD before rvalid -> all outputs 0 immediately; a subsequent IFU read completes normally.
- REQ-034 Slave rresp=2'b10 on an LSU read -> lsu_rresp=2'b10 and ifu_rvalid stays 0.
